decode_execute_reg: RTL and testbench

DECODE_EXECUTE_REG -- requirements
Module: decode_execute_reg

---
 rtl/decode_execute_reg.sv | 118 +++++++++++
 tb/tb_decode_execute_reg.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/decode_execute_reg.sv
// Decode-to-execute pipeline register with bubble insertion, stall hold and a
// saturating count of inserted bubbles.
module decode_execute_reg #(
   parameter int XLEN = 32,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            StallE,
   input  logic            FlushE,
   input  logic            RegWriteD,
   input  logic            MemWriteD,
   input  logic            JumpD,
   input  logic            BranchD,
   input  logic            ALUSrcD,
   input  logic [1:0]      ResultSrcD,
   input  logic [2:0]      ALUControlD,
   input  logic [2:0]      funct3D,
   input  logic [XLEN-1:0] RD1D,
   input  logic [XLEN-1:0] RD2D,
   input  logic [XLEN-1:0] ImmExtD,
   input  logic [XLEN-1:0] PCD,
   input  logic [XLEN-1:0] PCPlus4D,
   input  logic [4:0]      Rs1D,
   input  logic [4:0]      Rs2D,
   input  logic [4:0]      RdD,
   output logic            RegWriteE,
   output logic            MemWriteE,
   output logic            JumpE,
   output logic            BranchE,
   output logic            ALUSrcE,
   output logic [1:0]      ResultSrcE,
   output logic [2:0]      ALUControlE,
   output logic [2:0]      funct3E,
   output logic [XLEN-1:0] RD1E,
   output logic [XLEN-1:0] RD2E,
   output logic [XLEN-1:0] ImmExtE,
   output logic [XLEN-1:0] PCE,
   output logic [XLEN-1:0] PCPlus4E,
   output logic [4:0]      Rs1E,
   output logic [4:0]      Rs2E,
   output logic [4:0]      RdE,
   output logic            ValidE,
   output logic [CNTW-1:0] BubbleCntE
);

   // Counter increment that holds at all-ones instead of wrapping (CNTW >= 2).
   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
      sat_inc = (&v) ? v : v + {{(CNTW-1){1'b0}}, 1'b1};
   endfunction

   logic clear_s;
   logic load_s;

   // Per-edge action: reset and flush both clear, stall holds, otherwise load.
   always_comb begin
      clear_s = 1'b0;
      load_s  = 1'b0;
      if (rst || FlushE) begin
         clear_s = 1'b1;
      end else if (!StallE) begin
         load_s = 1'b1;
      end else begin
         load_s = 1'b0;
      end
   end

   // Stage payload and valid flag; a cleared stage is an inert NOP.
   always_ff @(posedge clk) begin
      if (clear_s) begin
         RegWriteE   <= 1'b0;
         MemWriteE   <= 1'b0;
         JumpE       <= 1'b0;
         BranchE     <= 1'b0;
         ALUSrcE     <= 1'b0;
         ResultSrcE  <= 2'b00;
         ALUControlE <= 3'b000;
         funct3E     <= 3'b000;
         RD1E        <= {XLEN{1'b0}};
         RD2E        <= {XLEN{1'b0}};
         ImmExtE     <= {XLEN{1'b0}};
         PCE         <= {XLEN{1'b0}};
         PCPlus4E    <= {XLEN{1'b0}};
         Rs1E        <= 5'b00000;
         Rs2E        <= 5'b00000;
         RdE         <= 5'b00000;
         ValidE      <= 1'b0;
      end else if (load_s) begin
         RegWriteE   <= RegWriteD;
         MemWriteE   <= MemWriteD;
         JumpE       <= JumpD;
         BranchE     <= BranchD;
         ALUSrcE     <= ALUSrcD;
         ResultSrcE  <= ResultSrcD;
         ALUControlE <= ALUControlD;
         funct3E     <= funct3D;
         RD1E        <= RD1D;
         RD2E        <= RD2D;
         ImmExtE     <= ImmExtD;
         PCE         <= PCD;
         PCPlus4E    <= PCPlus4D;
         Rs1E        <= Rs1D;
         Rs2E        <= Rs2D;
         RdE         <= RdD;
         ValidE      <= 1'b1;
      end
   end

   // Bubble statistics: reset clears without counting, each flush edge counts.
   always_ff @(posedge clk) begin
      if (rst) begin
         BubbleCntE <= {CNTW{1'b0}};
      end else if (FlushE) begin
         BubbleCntE <= sat_inc(BubbleCntE);
      end
   end

endmodule

// File: tb/tb_decode_execute_reg.sv
// Randomised bench for decode_execute_reg: a behavioural model pushes expected
// stage contents into a queue and a negedge monitor compares against two DUTs.
module tb_decode_execute_reg;

   typedef struct packed {
      logic        regwrite;
      logic        memwrite;
      logic        jump;
      logic        branch;
      logic        alusrc;
      logic [1:0]  resultsrc;
      logic [2:0]  aluctl;
      logic [2:0]  funct3;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [31:0] pcplus4;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } stage_t;

   typedef struct packed {
      stage_t      e;
      logic        v;
      logic [15:0] c16;
      logic [3:0]  c4;
   } exp_t;

   logic   clk = 1'b0;
   logic   rst = 1'b0;
   logic   StallE = 1'b0;
   logic   FlushE = 1'b0;
   stage_t d = '0;
   stage_t eo16, eo4;
   logic   v16, v4;
   logic [15:0] cnt16;
   logic [3:0]  cnt4;

   exp_t   q[$];
   int     checks = 0;
   int     errors = 0;

   stage_t      m_e = '0;
   logic        m_v = 1'b0;
   int unsigned m_bubbles16 = 0;
   int unsigned m_bubbles4 = 0;

   always #5 clk = ~clk;

   decode_execute_reg #(.XLEN(32), .CNTW(16)) dut16 (
      .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
      .RegWriteD(d.regwrite), .MemWriteD(d.memwrite), .JumpD(d.jump),
      .BranchD(d.branch), .ALUSrcD(d.alusrc), .ResultSrcD(d.resultsrc),
      .ALUControlD(d.aluctl), .funct3D(d.funct3), .RD1D(d.rd1), .RD2D(d.rd2),
      .ImmExtD(d.imm), .PCD(d.pc), .PCPlus4D(d.pcplus4), .Rs1D(d.rs1),
      .Rs2D(d.rs2), .RdD(d.rd),
      .RegWriteE(eo16.regwrite), .MemWriteE(eo16.memwrite), .JumpE(eo16.jump),
      .BranchE(eo16.branch), .ALUSrcE(eo16.alusrc), .ResultSrcE(eo16.resultsrc),
      .ALUControlE(eo16.aluctl), .funct3E(eo16.funct3), .RD1E(eo16.rd1),
      .RD2E(eo16.rd2), .ImmExtE(eo16.imm), .PCE(eo16.pc), .PCPlus4E(eo16.pcplus4),
      .Rs1E(eo16.rs1), .Rs2E(eo16.rs2), .RdE(eo16.rd),
      .ValidE(v16), .BubbleCntE(cnt16)
   );

   decode_execute_reg #(.XLEN(32), .CNTW(4)) dut4 (
      .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
      .RegWriteD(d.regwrite), .MemWriteD(d.memwrite), .JumpD(d.jump),
      .BranchD(d.branch), .ALUSrcD(d.alusrc), .ResultSrcD(d.resultsrc),
      .ALUControlD(d.aluctl), .funct3D(d.funct3), .RD1D(d.rd1), .RD2D(d.rd2),
      .ImmExtD(d.imm), .PCD(d.pc), .PCPlus4D(d.pcplus4), .Rs1D(d.rs1),
      .Rs2D(d.rs2), .RdD(d.rd),
      .RegWriteE(eo4.regwrite), .MemWriteE(eo4.memwrite), .JumpE(eo4.jump),
      .BranchE(eo4.branch), .ALUSrcE(eo4.alusrc), .ResultSrcE(eo4.resultsrc),
      .ALUControlE(eo4.aluctl), .funct3E(eo4.funct3), .RD1E(eo4.rd1),
      .RD2E(eo4.rd2), .ImmExtE(eo4.imm), .PCE(eo4.pc), .PCPlus4E(eo4.pcplus4),
      .Rs1E(eo4.rs1), .Rs2E(eo4.rs2), .RdE(eo4.rd),
      .ValidE(v4), .BubbleCntE(cnt4)
   );

   function automatic stage_t rnd_stage();
      logic [191:0] w;
      w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return stage_t'(w[$bits(stage_t)-1:0]);
   endfunction

   // Drive one cycle, then apply the stage rules to the model at the same edge.
   task automatic step(input logic r, input logic s, input logic f, input stage_t dv);
      exp_t x;
      @(negedge clk);
      rst = r; StallE = s; FlushE = f; d = dv;
      @(posedge clk);
      if (r) begin
         m_e = '0; m_v = 1'b0; m_bubbles16 = 0; m_bubbles4 = 0;
      end else if (f) begin
         m_e = '0; m_v = 1'b0;
         m_bubbles16 = m_bubbles16 + 1;
         m_bubbles4  = m_bubbles4 + 1;
      end else if (!s) begin
         m_e = dv; m_v = 1'b1;
      end
      x.e   = m_e;
      x.v   = m_v;
      x.c16 = (m_bubbles16 > 65535) ? 16'hFFFF : 16'(m_bubbles16);
      x.c4  = (m_bubbles4 > 15) ? 4'hF : 4'(m_bubbles4);
      q.push_back(x);
   endtask

   // Monitor: one expected entry per active edge, checked mid-cycle.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t x;
         x = q.pop_front();
         checks = checks + 4;
         if ({eo16, v16} !== {x.e, x.v}) begin
            errors = errors + 1;
            $display("FAIL stage16 got %h/%b want %h/%b", eo16, v16, x.e, x.v);
         end
         if (cnt16 !== x.c16) begin
            errors = errors + 1;
            $display("FAIL bubblecnt16 got %h want %h", cnt16, x.c16);
         end
         if ({eo4, v4} !== {x.e, x.v}) begin
            errors = errors + 1;
            $display("FAIL stage4 got %h/%b want %h/%b", eo4, v4, x.e, x.v);
         end
         if (cnt4 !== x.c4) begin
            errors = errors + 1;
            $display("FAIL bubblecnt4 got %h want %h", cnt4, x.c4);
         end
      end
   end

   initial begin
      stage_t t, t2, t3;
      // Reset dominates with every input high.
      step(1'b1, 1'b1, 1'b1, '1);
      // Directed load.
      t = '0;
      t.regwrite = 1'b1; t.resultsrc = 2'b01; t.aluctl = 3'b010;
      t.rd1 = 32'h0000_00AA; t.rd = 5'd5;
      step(1'b0, 1'b0, 1'b0, t);
      // Three stall cycles with changed operand, then release.
      t2 = t; t2.rd1 = 32'hFFFF_FFFF;
      repeat (3) step(1'b0, 1'b1, 1'b0, t2);
      step(1'b0, 1'b0, 1'b0, t2);
      // Flush beats stall; writes suppressed.
      t3 = t2; t3.regwrite = 1'b1; t3.memwrite = 1'b1;
      step(1'b0, 1'b1, 1'b1, t3);
      // Reset in the middle of a stall, then a clean load.
      step(1'b0, 1'b0, 1'b0, t);
      step(1'b0, 1'b1, 1'b0, t2);
      step(1'b1, 1'b1, 1'b0, t2);
      step(1'b0, 1'b0, 1'b0, t3);
      // Seventeen consecutive flushes from a fresh reset saturate the 4-bit count.
      step(1'b1, 1'b0, 1'b0, t);
      for (int i = 0; i < 17; i++) begin
         step(1'b0, 1'($urandom_range(0, 1)), 1'b1, rnd_stage());
      end
      // Random mix of load, stall, flush and occasional reset.
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 5) == 0), rnd_stage());
      end
      @(negedge clk);
      #1;
      checks = checks + 1;
      if (q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL drain got %0d pending want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
